// File: rtl/insn_mem_loader.sv
// Boot-time instruction memory loader: unpacks a length-prefixed little-endian
// byte stream into word writes starting at word 0, holding the CPU until a good load.
module insn_mem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        partial_q, partial_d;
  logic               byte_ready_q, byte_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               restart;
  logic               last_write;
  logic [LEN_W-1:0]   len_full;

  assign accept     = byte_valid && byte_ready_q;
  assign restart    = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign len_full   = {byte_in, len_q[7:0]};
  // word_idx has already advanced past the word being written this cycle
  assign last_write = wr_en_q && (32'(word_idx_q) == 32'(len_q));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN0;
      S_LEN0: begin
        if (abort)       state_d = S_ERR;
        else if (accept) state_d = S_LEN1;
      end
      S_LEN1: begin
        if (abort) state_d = S_ERR;
        else if (accept) begin
          if (len_full == '0)                   state_d = S_DONE;
          else if (32'(len_full) > MAX_WORDS)   state_d = S_ERR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (abort)           state_d = S_ERR;
        else if (last_write) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_comb begin
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    partial_d  = partial_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (restart) begin
      len_d      = '0;
      word_idx_d = '0;
      byte_cnt_d = '0;
      partial_d  = '0;
    end else if (accept) begin
      unique case (state_q)
        S_LEN0: len_d[7:0]  = byte_in;
        S_LEN1: len_d[15:8] = byte_in;
        S_DATA: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: partial_d[7:0]   = byte_in;
            2'd1: partial_d[15:8]  = byte_in;
            2'd2: partial_d[23:16] = byte_in;
            default: begin
              wr_en_d    = 1'b1;
              wr_data_d  = {byte_in, partial_q};
              wr_addr_d  = 32'({word_idx_q, 2'b00});
              word_idx_d = word_idx_q + IDX_W'(1);
              partial_d  = '0;
            end
          endcase
        end
        default: ;
      endcase
    end

    busy_d       = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
    byte_ready_d = busy_d;
    cpu_hold_d   = busy_d || (state_d == S_ERR);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      partial_q    <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      partial_q    <= partial_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
